alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command front-end for the 4-bit ALU stage. It accepts {sel, b, a} commands over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time to the ALU on registered operand lines, waits a fixed ALU latency, then captures the 8-bit ALU result. The captured result is presented downstream on a valid/ready result port, in order.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, at least 2
ALU_LAT, 1, cycles from operand issue to the result capture edge; at least 1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_sel  in  3  opcode: 000 ADD, 001 AND, 010 OR, 011 XOR, 100 NOT A
alu_a  out  4  registered operand A to the ALU
alu_b  out  4  registered operand B to the ALU
alu_sel  out  3  registered opcode to the ALU
alu_result  in  8  ALU output
res_valid  out  1  result available
res_ready  in  1  downstream accepts the result
res_data  out  8  captured result
res_sel  out  3  opcode that produced res_data
busy  out  1  state != IDLE or FIFO non-empty
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: one rst cycle fully resets the block.
  - alu_a, alu_b, alu_sel, res_data, res_sel = 0.
  - res_valid = 0, busy = 0, count = 0.
  - FIFO empty, state IDLE.
  - cmd_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all queued commands, any in-flight issue and any held result. No stale result appears after reset.
- cmd_ready = !full, taken from registered occupancy. There is no push-through when full, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle are legal when not full; count is unchanged.
- A command pushed into an empty FIFO can be popped on the next edge at the earliest (no bypass).
- FSM states:
  - IDLE: on an edge with FIFO non-empty, pop the head, load alu_a/alu_b/alu_sel, set wait counter = ALU_LAT, go to WAIT.
  - WAIT: decrement the counter each edge. On the edge where the counter equals 1, register alu_result into res_data and alu_sel into res_sel, set res_valid = 1, go to HOLD.
  - HOLD: res_valid = 1; res_data and res_sel are stable. On an edge with res_ready = 1, clear res_valid.
    - If the FIFO is non-empty on that same edge, pop and reload the alu_* registers, go to WAIT.
    - Otherwise go to IDLE.
- alu_* hold the last issued command until the next pop; they never change during WAIT or HOLD.
- Latency with ALU_LAT = 1 and an idle, empty sequencer: command accepted at edge T, alu_* valid after T+1, res_valid high after T+2. In general, res_valid rises ALU_LAT+1 edges after acceptance.
- Throughput with res_ready held high: one result per ALU_LAT+1 cycles.
- Opcodes 101–111 are passed through unfiltered; res_data is whatever the ALU returns.
- Capacity: DEPTH queued commands plus one in flight or held.

Optional Feature:
ALU_SEQ_ZERO_FLAG_EN
- Defined: adds output res_zero (1 bit).
  - Registered on the capture edge as (alu_result == 8'h00).
  - Held with res_data; reset value 0.
- Undefined: the res_zero port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD, OP_AND, OP_OR, OP_XOR, OP_NOT;
  - typedef alu_cmd_t packed {sel[2:0], b[3:0], a[3:0]};
  - FSM state enum {IDLE, WAIT, HOLD}.
- Sub-module alu_seq_fifo: synchronous FIFO of alu_cmd_t with DEPTH, push/pop, full/empty/count; synchronous active-high reset.

Test Plan:
1. Hold rst for 2 cycles, then release -> res_valid = 0, cmd_ready = 1, count = 0, alu_* = 0, busy = 0.
2. a=3, b=2, sel=000, res_ready=1, ALU_LAT=1 -> alu_a=3, alu_b=2, alu_sel=0 one cycle after acceptance; res_valid=1, res_data=8'h05, res_sel=0 two cycles after acceptance.
3. With res_ready=0, offer ADD, AND, OR, XOR, NOT (a=3, b=2) plus a 6th command -> the first 5 are accepted, then cmd_ready=0, count=4. Then raise res_ready -> results in order 05, 02, 03, 01, 0C (per the bench ALU model); the 6th is accepted after the first pop.
4. Hold res_ready=0 for 10 cycles while in HOLD -> res_data, res_sel and alu_* are stable; count does not change.
5. Assert rst in HOLD with 3 commands queued -> next cycle res_valid=0, count=0, cmd_ready=1; no further results appear without new commands.
6. ALU_LAT=3 with the macro defined, a=0, b=5, sel=001 -> res_valid 4 cycles after acceptance, res_data=8'h00, res_zero=1.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer.
// Provides the opcode constants, the packed command word stored in the
// command FIFO, and the sequencer FSM state encoding.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] b;
        logic [3:0] a;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle for the ALU command sequencer.
// Groups the command port (valid/ready), the registered ALU operand lines
// and the ALU result input, the result port (valid/ready) and the status
// outputs busy/count.
//   slave  : the sequencer side
//   master : the environment side (command source, ALU, result sink)
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds the res_zero result flag.
interface alu_cmd_sequencer_if #(
    parameter int DEPTH = 4
) ();
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [3:0]               cmd_a;
    logic [3:0]               cmd_b;
    logic [2:0]               cmd_sel;
    logic [3:0]               alu_a;
    logic [3:0]               alu_b;
    logic [2:0]               alu_sel;
    logic [7:0]               alu_result;
    logic                     res_valid;
    logic                     res_ready;
    logic [7:0]               res_data;
    logic [2:0]               res_sel;
    logic                     busy;
    logic [$clog2(DEPTH):0]   count;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic                     res_zero;
`endif

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
               busy, count
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , output res_zero
`endif
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
               busy, count
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , input res_zero
`endif
    );
endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Command FIFO for the ALU command sequencer.
// Synchronous FIFO of alu_cmd_t, DEPTH entries (power of 2, >= 2).
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data (head,
// valid when !empty), full, empty, count (registered occupancy).
// A push while full and a pop while empty are ignored; the head is only
// readable from the cycle after it was written (no bypass).
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  alu_cmd_t                push_data,
    input  logic                    pop,
    output alu_cmd_t                pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    alu_cmd_t       mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           push_en, pop_en;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer (top).
// Accepts {sel, b, a} commands on bus.cmd_* (valid/ready), queues them in a
// DEPTH-entry FIFO, issues one at a time on registered bus.alu_* lines,
// captures bus.alu_result ALU_LAT edges after issue and presents it in order
// on bus.res_* (valid/ready). bus.busy / bus.count report activity/occupancy.
// Ports: clk, rst (sync, active-high), bus (alu_cmd_sequencer_if.slave).
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds bus.res_zero (result == 0).
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_cmd_sequencer_if.slave    bus
);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam int AW = $clog2(DEPTH);

    seq_state_e     state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]     alu_a_q, alu_a_d;
    logic [3:0]     alu_b_q, alu_b_d;
    logic [2:0]     alu_sel_q, alu_sel_d;
    logic [7:0]     res_data_q, res_data_d;
    logic [2:0]     res_sel_q, res_sel_d;
    logic           res_valid_q, res_valid_d;
    logic           res_zero_q, res_zero_d;

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    alu_cmd_t       push_cmd, head_cmd;
    logic [AW:0]    fifo_count;

    assign push_cmd  = {bus.cmd_sel, bus.cmd_b, bus.cmd_a};
    // Ready comes from registered occupancy only: a pop in the same cycle
    // does not open a slot for a push while full.
    assign fifo_push = bus.cmd_valid && !fifo_full;

    alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register (plus the datapath registers it sequences)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
            res_valid_q <= res_valid_d;
            res_zero_q  <= res_zero_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = WAIT;
            WAIT:    if (wait_cnt_q == CW'(1)) state_d = HOLD;
            HOLD:    if (bus.res_ready) state_d = fifo_empty ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        fifo_pop    = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;
        res_valid_d = res_valid_q;
        res_zero_d  = res_zero_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    alu_a_d    = head_cmd.a;
                    alu_b_d    = head_cmd.b;
                    alu_sel_d  = head_cmd.sel;
                    wait_cnt_d = CW'(ALU_LAT);
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - CW'(1);
                if (wait_cnt_q == CW'(1)) begin
                    res_data_d  = bus.alu_result;
                    res_sel_d   = alu_sel_q;
                    res_zero_d  = (bus.alu_result == 8'h00);
                    res_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    // Back-to-back issue: reload while the result leaves.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        alu_a_d    = head_cmd.a;
                        alu_b_d    = head_cmd.b;
                        alu_sel_d  = head_cmd.sel;
                        wait_cnt_d = CW'(ALU_LAT);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_sel   = res_sel_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
    assign bus.count     = fifo_count;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign bus.res_zero  = res_zero_q;
`else
    logic unused_zero;
    assign unused_zero   = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer.
// Two instances: u_dut (ALU_LAT=1) carries the scoreboard-checked traffic;
// u_dut3 (ALU_LAT=3) checks the longer capture latency. The bench models the
// external ALU; for ALU_LAT=3 its result only becomes correct ALU_LAT-1
// cycles after the operands change, so an early capture reads a stale value.
// Honours ALU_SEQ_ZERO_FLAG_EN for the res_zero checks.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.DEPTH(DEPTH)) ifa ();
    alu_cmd_sequencer_if #(.DEPTH(DEPTH)) ifb ();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(1)) u_dut (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(LAT_B)) u_dut3 (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural ALU: ADD is a 5-bit sum, NOT A is the 4-bit complement;
    // reserved opcodes return a distinctive pattern the sequencer must pass on.
    function automatic logic [7:0] alu_model(input logic [2:0] sel,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        case (sel)
            3'd0:    return 8'(a) + 8'(b);
            3'd1:    return {4'h0, a & b};
            3'd2:    return {4'h0, a | b};
            3'd3:    return {4'h0, a ^ b};
            3'd4:    return {4'h0, ~a};
            default: return {sel, 1'b1, a};
        endcase
    endfunction

    assign ifa.alu_result = alu_model(ifa.alu_sel, ifa.alu_a, ifa.alu_b);

    logic [7:0] b_pipe0, b_pipe1;
    always @(posedge clk) begin
        b_pipe0 <= alu_model(ifb.alu_sel, ifb.alu_a, ifb.alu_b);
        b_pipe1 <= b_pipe0;
    end
    assign ifb.alu_result = b_pipe1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (!rst && ifa.cmd_valid && ifa.cmd_ready)
            exp_q.push_back('{sel: ifa.cmd_sel,
                              data: alu_model(ifa.cmd_sel, ifa.cmd_a, ifa.cmd_b)});
    end

    logic       held = 1'b0;
    logic [7:0] prev_data;
    logic [2:0] prev_sel;
    logic [3:0] prev_alu_a, prev_alu_b;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else if (ifa.res_valid) begin
            if (held) begin
                check("hold_res_data", 32'(ifa.res_data), 32'(prev_data));
                check("hold_res_sel",  32'(ifa.res_sel),  32'(prev_sel));
                check("hold_alu_a",    32'(ifa.alu_a),    32'(prev_alu_a));
                check("hold_alu_b",    32'(ifa.alu_b),    32'(prev_alu_b));
            end
            if (ifa.res_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(ifa.res_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(ifa.res_data), 32'(e.data));
                    check("res_sel",  32'(ifa.res_sel),  32'(e.sel));
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    check("res_zero", 32'(ifa.res_zero), 32'(e.data == 8'h00));
`endif
                end
            end else begin
                held       = 1'b1;
                prev_data  = ifa.res_data;
                prev_sel   = ifa.res_sel;
                prev_alu_a = ifa.alu_a;
                prev_alu_b = ifa.alu_b;
            end
        end else begin
            held = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send_a(input logic [2:0] sel, input logic [3:0] a,
                          input logic [3:0] b, input int budget);
        ifa.cmd_sel = sel; ifa.cmd_a = a; ifa.cmd_b = b; ifa.cmd_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifa.cmd_ready) begin
                @(posedge clk); #1;
                ifa.cmd_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        ifa.cmd_valid = 1'b0;
        check("send_a_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ifa.res_valid) break;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_b(input logic [2:0] sel, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] exp_d);
        ifb.cmd_sel = sel; ifb.cmd_a = a; ifb.cmd_b = b; ifb.cmd_valid = 1'b1;
        ifb.res_ready = 1'b0;
        @(negedge clk);
        check("b_cmd_ready", 32'(ifb.cmd_ready), 32'd1);
        @(posedge clk); #1;
        ifb.cmd_valid = 1'b0;
        for (int k = 0; k <= LAT_B + 1; k++) begin
            @(negedge clk);
            check("b_res_valid_timing", 32'(ifb.res_valid), 32'(k == LAT_B + 1));
        end
        check("b_res_data", 32'(ifb.res_data), 32'(exp_d));
        check("b_res_sel",  32'(ifb.res_sel),  32'(sel));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("b_res_zero", 32'(ifb.res_zero), 32'(exp_d == 8'h00));
`endif
        @(posedge clk); #1;
        ifb.res_ready = 1'b1;
        @(posedge clk); #1;
        ifb.res_ready = 1'b0;
        @(negedge clk);
        check("b_res_valid_cleared", 32'(ifb.res_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    logic       drv_done;
    logic [7:0] snap_data;
    logic [2:0] snap_sel;
    logic [3:0] snap_a;
    logic [2:0] snap_count;

    initial begin
        rst = 1'b1;
        ifa.cmd_valid = 1'b0; ifa.cmd_a = '0; ifa.cmd_b = '0; ifa.cmd_sel = '0;
        ifa.res_ready = 1'b0;
        ifb.cmd_valid = 1'b0; ifb.cmd_a = '0; ifb.cmd_b = '0; ifb.cmd_sel = '0;
        ifb.res_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_res_valid", 32'(ifa.res_valid), 32'd0);
        check("rst_cmd_ready", 32'(ifa.cmd_ready), 32'd1);
        check("rst_count",     32'(ifa.count),     32'd0);
        check("rst_alu_ops",   32'({ifa.alu_sel, ifa.alu_b, ifa.alu_a}), 32'd0);
        check("rst_res",       32'({ifa.res_sel, ifa.res_data}), 32'd0);
        check("rst_busy",      32'(ifa.busy),      32'd0);
        check("rst_b_busy",    32'(ifb.busy),      32'd0);
        @(posedge clk); #1;

        // ---- ALU_LAT=3 instance: stale-capture sensitive sequence ----
        run_b(OP_ADD, 4'd3, 4'd2, 8'h05);
        run_b(OP_AND, 4'd0, 4'd5, 8'h00);

        // ---- single ADD latency ----
        ifa.res_ready = 1'b1;
        send_a(OP_ADD, 4'd3, 4'd2, 10);
        @(negedge clk);
        check("lat_res_valid_t0", 32'(ifa.res_valid), 32'd0);
        @(negedge clk);
        check("lat_alu_ops_t1", 32'({ifa.alu_sel, ifa.alu_b, ifa.alu_a}),
              32'({OP_ADD, 4'd2, 4'd3}));
        check("lat_res_valid_t1", 32'(ifa.res_valid), 32'd0);
        @(negedge clk);
        check("lat_res_valid_t2", 32'(ifa.res_valid), 32'd1);
        check("lat_res_data_t2",  32'(ifa.res_data),  32'h05);
        @(posedge clk); #1;
        drain(20);

        // ---- fill to full with results stalled ----
        ifa.res_ready = 1'b0;
        fork
            begin
                send_a(OP_ADD, 4'd3, 4'd2, 40);
                send_a(OP_AND, 4'd3, 4'd2, 40);
                send_a(OP_OR,  4'd3, 4'd2, 40);
                send_a(OP_XOR, 4'd3, 4'd2, 40);
                send_a(OP_NOT, 4'd3, 4'd2, 40);
                send_a(OP_XOR, 4'd9, 4'd6, 40);
            end
            begin
                repeat (7) @(negedge clk);
                check("full_count",     32'(ifa.count),     32'd4);
                check("full_cmd_ready", 32'(ifa.cmd_ready), 32'd0);
                check("full_busy",      32'(ifa.busy),      32'd1);
                @(posedge clk); #1;
                ifa.res_ready = 1'b1;
            end
        join
        drain(60);

        // ---- long stall in HOLD ----
        ifa.res_ready = 1'b0;
        send_a(OP_ADD, 4'd7, 4'd8, 10);
        send_a(OP_OR,  4'd1, 4'd2, 10);
        send_a(OP_NOT, 4'd5, 4'd0, 10);
        for (int i = 0; i < 10 && !ifa.res_valid; i++) @(negedge clk);
        check("stall_res_valid", 32'(ifa.res_valid), 32'd1);
        check("stall_res_data",  32'(ifa.res_data),  32'h0F);
        snap_data = ifa.res_data; snap_sel = ifa.res_sel;
        snap_a = ifa.alu_a; snap_count = ifa.count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_data",  32'(ifa.res_data), 32'(snap_data));
            check("stall_sel",   32'(ifa.res_sel),  32'(snap_sel));
            check("stall_alu_a", 32'(ifa.alu_a),    32'(snap_a));
            check("stall_count", 32'(ifa.count),    32'(snap_count));
        end

        // ---- reset while holding with 3 queued ----
        @(posedge clk); #1;
        send_a(OP_AND, 4'd15, 4'd15, 10);
        @(negedge clk);
        check("pre_rst_count", 32'(ifa.count), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_res_valid", 32'(ifa.res_valid), 32'd0);
        check("mid_rst_count",     32'(ifa.count),     32'd0);
        check("mid_rst_cmd_ready", 32'(ifa.cmd_ready), 32'd1);
        check("mid_rst_busy",      32'(ifa.busy),      32'd0);
        @(posedge clk); #1;
        ifa.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_result", 32'(ifa.res_valid), 32'd0);
        end
        @(posedge clk); #1;

        // ---- randomized traffic with random backpressure ----
        drv_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_a(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 50);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    ifa.res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        ifa.res_ready = 1'b1;
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
